// File: rtl/ramp_pwm_pkg.sv
// Shared types and defaults for the ramp_pwm ready/edge path.
package ramp_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } pulse_state_t;

    localparam int DEFAULT_WIDTH_BITS = 16;
    localparam int DEFAULT_DROP_BITS  = 8;

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into a programmable-width ready level
// followed by a guaranteed low gap; one pending trigger is held, extras are counted.
module pulse_stretcher
    import ramp_pwm_pkg::*;
#(
    parameter int WIDTH_BITS       = DEFAULT_WIDTH_BITS,
    parameter int GAP_CYCLES       = 2,
    parameter bit RETRIGGER_ENABLE = 1'b0,
    parameter int DROP_BITS        = DEFAULT_DROP_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger,
    input  logic [WIDTH_BITS-1:0] width,
    output logic                  ready,
    output logic                  done,
    output logic                  busy,
    output logic [DROP_BITS-1:0]  drop_count
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]      GAP_ONE  = GAP_W'(1);
    localparam logic [WIDTH_BITS-1:0] W_ONE    = WIDTH_BITS'(1);

    generate
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("pulse_stretcher: GAP_CYCLES must be at least 1");
        end
    endgenerate

    pulse_state_t          state;
    logic [WIDTH_BITS-1:0] high_cnt;
    logic [WIDTH_BITS-1:0] pend_width;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  pending;

    logic                  trig_valid;
    logic                  gap_last;
    logic                  queue_req;
    logic                  drop_req;
    logic                  start_req;
    logic [WIDTH_BITS-1:0] start_width;

    assign trig_valid = trigger && (width != '0);
    assign gap_last   = (gap_cnt == '0);

    // A trigger is "queued" whenever it cannot start or reload a pulse itself.
    always_comb begin
        queue_req   = 1'b0;
        start_req   = 1'b0;
        start_width = width;
        unique case (state)
            IDLE: start_req = trig_valid;
            HIGH: queue_req = trig_valid && !RETRIGGER_ENABLE;
            GAP: begin
                queue_req = trig_valid && !(gap_last && !pending);
                if (gap_last) begin
                    if (pending) begin
                        start_req   = 1'b1;
                        start_width = pend_width;
                    end else begin
                        start_req = trig_valid;
                    end
                end
            end
            default: begin
                queue_req = 1'b0;
                start_req = 1'b0;
            end
        endcase
    end

    // On the last gap cycle the new trigger replaces the pending one that is starting.
    assign drop_req = queue_req && pending && !(state == GAP && gap_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ready    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            high_cnt <= '0;
            gap_cnt  <= '0;
            pending  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (queue_req && !pending) begin
                pending    <= 1'b1;
                pend_width <= width;
            end
            unique case (state)
                IDLE: ;
                HIGH: begin
                    if (RETRIGGER_ENABLE && trig_valid) begin
                        high_cnt <= width - W_ONE;
                    end else if (high_cnt == '0) begin
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                        ready   <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        high_cnt <= high_cnt - W_ONE;
                    end
                end
                GAP: begin
                    if (!gap_last) begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end else if (pending) begin
                        pending <= trig_valid;
                        if (trig_valid) pend_width <= width;
                    end else if (!trig_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (start_req) begin
                state    <= HIGH;
                high_cnt <= start_width - W_ONE;
                ready    <= 1'b1;
                busy     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop_req && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_BITS'(1);
        end
    end

endmodule
